// File: rtl/mem_pkg.sv
// Shared memory-side types for the instruction memory and its byte-stream loader.
package mem_pkg;
  typedef logic [31:0] word_t;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE
  } loader_state_e;
endpackage

// File: rtl/word_packer.sv
// Assembles little-endian bytes into 32-bit words and issues one imem write per word.
module word_packer
  import mem_pkg::*;
#(
  parameter int AddrW = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             byte_en,
  input  logic [7:0]       byte_in,
  output logic [1:0]       lane,
  output logic             we,
  output logic [AddrW-1:0] waddr,
  output word_t            wdata
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane  <= '0;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= byte_en && (lane == 2'd3);
      if (clr) begin
        lane  <= '0;
        waddr <= '0;
      end else begin
        // address moves after the write cycle so waddr/wdata are stable while we is high
        if (we) waddr <= waddr + AddrW'(4);
        if (byte_en) begin
          wdata[{lane, 3'b000} +: 8] <= byte_in;
          lane                       <= lane + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed program loader: A5, 16-bit word count, LE words, XOR checksum -> imem writes.
module imem_loader
  import mem_pkg::*;
#(
  parameter  int MemSize       = 'h0000_1000,
  parameter  int TimeoutCycles = 1_000_000,
  localparam int MemAddrWidth  = $clog2(MemSize)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    we,
  output logic [MemAddrWidth-1:0] waddr,
  output word_t                   wdata,
  output logic                    cpu_hold,
  output logic                    done,
  output logic                    error,
  output logic                    err_sticky
);

  localparam int unsigned MaxWords = int'(MemSize) / 4;
  localparam int          IdleW    = $clog2(TimeoutCycles);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TimeoutCycles - 2);

  loader_state_e    state;
  logic [7:0]       len_lo;
  logic [15:0]      n_words;
  logic [15:0]      word_idx;
  logic [7:0]       csum;
  logic [IdleW-1:0] idle_cnt;
  logic [1:0]       lane;
  logic [15:0]      len;
  logic             in_frame;
  logic             start;
  logic             byte_en;
  logic             timeout;

  assign len      = {rx_data, len_lo};
  assign in_frame = (state == ST_LEN0) || (state == ST_LEN1) ||
                    (state == ST_DATA) || (state == ST_CSUM);
  assign start    = (state == ST_IDLE) && rx_valid && (rx_data == LOADER_MAGIC);
  assign byte_en  = (state == ST_DATA) && rx_valid;
  // decided one cycle early so the registered error lands on the last idle cycle
  assign timeout  = in_frame && !rx_valid && (idle_cnt == IdleLast);

  word_packer #(.AddrW(MemAddrWidth)) u_packer (
    .clk     (clk),
    .reset   (reset),
    .clr     (start),
    .byte_en (byte_en),
    .byte_in (rx_data),
    .lane    (lane),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      len_lo     <= '0;
      n_words    <= '0;
      word_idx   <= '0;
      csum       <= '0;
      idle_cnt   <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (in_frame && !rx_valid) idle_cnt <= idle_cnt + 1'b1;
      else                       idle_cnt <= '0;

      // every abort passes through ST_DONE so cpu_hold drops one cycle after the pulse
      if (timeout) begin
        error      <= 1'b1;
        err_sticky <= 1'b1;
        state      <= ST_DONE;
      end else begin
        unique case (state)
          ST_IDLE: if (start) begin
            cpu_hold   <= 1'b1;
            err_sticky <= 1'b0;
            csum       <= '0;
            state      <= ST_LEN0;
          end
          ST_LEN0: if (rx_valid) begin
            len_lo <= rx_data;
            state  <= ST_LEN1;
          end
          ST_LEN1: if (rx_valid) begin
            n_words  <= len;
            word_idx <= '0;
            if (len == 16'd0) begin
              state <= ST_CSUM;
            end else if (32'(len) > MaxWords) begin
              error      <= 1'b1;
              err_sticky <= 1'b1;
              state      <= ST_DONE;
            end else begin
              state <= ST_DATA;
            end
          end
          ST_DATA: if (rx_valid) begin
            csum <= csum ^ rx_data;
            if (lane == 2'd3) begin
              if (word_idx == n_words - 16'd1) state <= ST_CSUM;
              else                             word_idx <= word_idx + 16'd1;
            end
          end
          ST_CSUM: if (rx_valid) begin
            if (rx_data == csum) begin
              done <= 1'b1;
            end else begin
              error      <= 1'b1;
              err_sticky <= 1'b1;
            end
            state <= ST_DONE;
          end
          ST_DONE: begin
            cpu_hold <= 1'b0;
            state    <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: hand-written timing sequences plus a table of randomized frames.
module tb_imem_loader;
  localparam int MEMSIZE = 'h1000;
  localparam int MAXW    = MEMSIZE / 4;
  localparam int TMO     = 16;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        we;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic        err_sticky;

  imem_loader #(.MemSize(MEMSIZE), .TimeoutCycles(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int unsigned addr; int unsigned data; } wr_t;
  typedef struct { int n; bit bad; int gapmax; bit exp_done; bit exp_err; } row_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  done_cnt = 0;
  int  err_cnt = 0;
  int  we_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // write scoreboard and pulse counters
  always @(negedge clk) begin : mon
    wr_t e;
    if (!reset) begin
      if (done || error) chk("done_error_exclusive", 32'(done & error), 0);
      if (done)  done_cnt++;
      if (error) err_cnt++;
      if (we) begin
        we_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_we: waddr=%0h wdata=%0h, required no write", waddr, wdata);
        end else begin
          e = exp_q.pop_front();
          chk("we_addr", 32'(waddr), e.addr);
          chk("we_data", wdata, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic sb(input logic [7:0] b);
    send_byte(b, 0);
  endtask

  // reference: frame built from random bytes; expected words are plain LE arithmetic
  task automatic run_row(input string nm, input row_t r);
    logic [7:0]  q[$];
    logic [7:0]  cs;
    logic [7:0]  bb;
    int unsigned w;
    int          d0, e0, w0, nw;
    cs = 8'h00;
    d0 = done_cnt; e0 = err_cnt; w0 = we_cnt;
    q.push_back(8'hA5);
    q.push_back(8'(r.n));
    q.push_back(8'(r.n >> 8));
    nw = (r.n <= MAXW) ? r.n : 0;
    for (int i = 0; i < nw; i++) begin
      w = 0;
      for (int k = 0; k < 4; k++) begin
        bb = 8'($urandom);
        cs = cs ^ bb;
        q.push_back(bb);
        w = w + int'(bb) * (1 << (8 * k));
      end
      exp_q.push_back('{32'(4 * i), w});
    end
    if (r.n <= MAXW) q.push_back(r.bad ? ~cs : cs);
    foreach (q[j]) send_byte(q[j], int'($urandom_range(0, r.gapmax)));
    repeat (3) tick();
    chk({nm, "_done"},    32'(done_cnt - d0), 32'(r.exp_done));
    chk({nm, "_error"},   32'(err_cnt - e0),  32'(r.exp_err));
    chk({nm, "_writes"},  32'(we_cnt - w0),   32'(nw));
    chk({nm, "_sticky"},  32'(err_sticky),    32'(r.exp_err));
    chk({nm, "_hold"},    32'(cpu_hold),      0);
    chk({nm, "_pending"}, 32'(exp_q.size()),  0);
  endtask

  row_t rows[8];
  int   d0, e0, w0;

  initial begin
    rows[0] = '{1,      0, 0, 1, 0};
    rows[1] = '{3,      0, 3, 1, 0};
    rows[2] = '{5,      1, 2, 0, 1};
    rows[3] = '{16,     0, 0, 1, 0};
    rows[4] = '{0,      0, 1, 1, 0};
    rows[5] = '{MAXW,   0, 0, 1, 0};
    rows[6] = '{MAXW+1, 0, 0, 0, 1};
    rows[7] = '{'hFFFF, 0, 1, 0, 1};

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) tick();
    chk("reset_ctrl", {27'd0, we, cpu_hold, done, error, err_sticky}, 0);
    chk("reset_waddr", 32'(waddr), 0);
    chk("reset_wdata", wdata, 0);
    reset = 1'b0;
    tick();

    // nominal two-word frame, back-to-back bytes
    exp_q.push_back('{0, 32'h13});
    exp_q.push_back('{4, 32'h6F});
    d0 = done_cnt;
    sb(8'hA5); chk("s1_hold_after_magic", 32'(cpu_hold), 1);
    sb(8'h02); sb(8'h00); sb(8'h13); sb(8'h00); sb(8'h00);
    chk("s1_no_early_we", 32'(we), 0);
    sb(8'h00);
    chk("s1_we0", 32'(we), 1); chk("s1_waddr0", 32'(waddr), 0); chk("s1_wdata0", wdata, 32'h13);
    sb(8'h6F);
    chk("s1_waddr_inc", 32'(waddr), 4); chk("s1_we_width", 32'(we), 0);
    sb(8'h00); sb(8'h00); sb(8'h00);
    chk("s1_we1", 32'(we), 1); chk("s1_wdata1", wdata, 32'h6F);
    sb(8'h7C);
    chk("s1_done", 32'(done), 1); chk("s1_hold_with_done", 32'(cpu_hold), 1);
    tick();
    chk("s1_done_width", 32'(done), 0); chk("s1_hold_release", 32'(cpu_hold), 0);
    chk("s1_done_count", 32'(done_cnt - d0), 1);

    // bad checksum: writes still happen, then abort
    exp_q.push_back('{0, 32'h13});
    exp_q.push_back('{4, 32'h6F});
    d0 = done_cnt;
    sb(8'hA5); sb(8'h02); sb(8'h00);
    sb(8'h13); sb(8'h00); sb(8'h00); sb(8'h00);
    sb(8'h6F); sb(8'h00); sb(8'h00); sb(8'h00);
    sb(8'h00);
    chk("s2_error", 32'(error), 1); chk("s2_sticky", 32'(err_sticky), 1);
    chk("s2_hold_with_error", 32'(cpu_hold), 1);
    tick();
    chk("s2_error_width", 32'(error), 0); chk("s2_hold_release", 32'(cpu_hold), 0);
    chk("s2_no_done", 32'(done_cnt - d0), 0); chk("s2_pending", 32'(exp_q.size()), 0);

    // oversize count aborts right after the LEN1 byte
    w0 = we_cnt;
    sb(8'hA5); sb(8'h01);
    chk("s3_no_error_yet", 32'(error), 0);
    sb(8'h04);
    chk("s3_error", 32'(error), 1);
    repeat (3) tick();
    chk("s3_no_writes", 32'(we_cnt - w0), 0);

    // a 14-cycle gap survives; a stall then times out on the 16th idle cycle
    e0 = err_cnt;
    sb(8'hA5); sb(8'h01); sb(8'h00);
    send_byte(8'h11, TMO - 2);
    chk("s4_gap_tolerated", 32'(err_cnt - e0), 0);
    sb(8'h22);
    repeat (TMO - 2) tick();
    chk("s4_no_error_15th", 32'(error), 0);
    tick();
    chk("s4_error_16th", 32'(error), 1); chk("s4_hold_still", 32'(cpu_hold), 1);
    tick();
    chk("s4_hold_drop", 32'(cpu_hold), 0); chk("s4_sticky", 32'(err_sticky), 1);
    chk("s4_error_count", 32'(err_cnt - e0), 1);

    // garbage in IDLE ignored; magic clears err_sticky; empty frame completes
    d0 = done_cnt; w0 = we_cnt;
    sb(8'h00); sb(8'hFF); sb(8'h5A);
    chk("s5_garbage_no_hold", 32'(cpu_hold), 0);
    sb(8'hA5);
    chk("s5_sticky_cleared", 32'(err_sticky), 0); chk("s5_hold", 32'(cpu_hold), 1);
    sb(8'h00); sb(8'h00); sb(8'h00);
    chk("s5_done", 32'(done), 1);
    repeat (3) tick();
    chk("s5_done_count", 32'(done_cnt - d0), 1); chk("s5_no_writes", 32'(we_cnt - w0), 0);

    // asynchronous reset in the middle of DATA
    exp_q.push_back('{0, 32'h44332211});
    sb(8'hA5); sb(8'h02); sb(8'h00);
    sb(8'h11); sb(8'h22); sb(8'h33); sb(8'h44); sb(8'h55);
    chk("s6_pre_waddr", 32'(waddr), 4); chk("s6_pre_hold", 32'(cpu_hold), 1);
    #2 reset = 1'b1;
    #1;
    chk("s6_rst_ctrl", {27'd0, we, cpu_hold, done, error, err_sticky}, 0);
    chk("s6_rst_waddr", 32'(waddr), 0);
    chk("s6_rst_wdata", wdata, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("s6_pending", 32'(exp_q.size()), 0);
    run_row("s6_reload", '{2, 0, 0, 1, 0});

    foreach (rows[i]) run_row($sformatf("row%0d", i), rows[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
